// File: rtl/jtkcpu_bussrv_pkg.sv
// Types shared by the jtkcpu bus responder, its interface and its bench.
package jtkcpu_bussrv_pkg;
`include "jtkcpu_bussrv.vh"

    typedef enum logic [1:0] {
        ST_IDLE = BUSSRV_ST_IDLE,
        ST_WAIT = BUSSRV_ST_WAIT,
        ST_ROM  = BUSSRV_ST_ROM,
        ST_ACK  = BUSSRV_ST_ACK
    } state_t;

    // What the WAIT state completes once its counter expires
    typedef enum logic [1:0] {
        RG_RAM   = 2'd0,
        RG_ROMWR = 2'd1,
        RG_UNMAP = 2'd2
    } region_t;

    localparam int CNT_W = 8;
endpackage

// File: rtl/jtkcpu_bussrv_if.sv
// CPU-side bus cycle and ROM request port of the jtkcpu bus responder.
interface jtkcpu_bussrv_if #(
    parameter int ROM_AW = 16
);
    // Handshakes: the CPU holds as high with stable addr/we/cpu_dout until
    // dtack is seen, then drops as; dtack stays high until a cen edge sees
    // as low. rom_cs stays high with stable rom_addr until the first clk with
    // rom_ok, and rom_data is only taken on that clk.
    logic              as;
    logic              we;
    logic [23:0]       addr;
    logic [7:0]        cpu_dout;
    logic [7:0]        cpu_din;
    logic              dtack;
    logic              rom_cs;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              rom_ok;
    logic              buserr;

    modport slave (
        input  as, we, addr, cpu_dout, rom_data, rom_ok,
        output cpu_din, dtack, rom_cs, rom_addr, buserr
    );

    modport master (
        output as, we, addr, cpu_dout, rom_data, rom_ok,
        input  cpu_din, dtack, rom_cs, rom_addr, buserr
    );
endinterface

// File: rtl/jtkcpu_bussrv.vh
// Shared encodings for the jtkcpu bus responder: FSM state codes and the
// value returned to the CPU when an access hits unmapped space.
localparam logic [1:0] BUSSRV_ST_IDLE  = 2'd0;
localparam logic [1:0] BUSSRV_ST_WAIT  = 2'd1;
localparam logic [1:0] BUSSRV_ST_ROM   = 2'd2;
localparam logic [1:0] BUSSRV_ST_ACK   = 2'd3;
localparam logic [7:0] BUSSRV_UNMAPPED = 8'hFF;

// File: rtl/jtkcpu_bussrv_ram.sv
// Single-port byte RAM with registered read, shaped for block RAM inference.
module jtkcpu_bussrv_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          i_cen,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_din,
    output logic [7:0]    o_dout
);
    logic [7:0] r_mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (i_we && i_cen) r_mem[i_addr] <= i_din;
        o_dout <= r_mem[i_addr];
    end
endmodule

// File: rtl/jtkcpu_bussrv.sv
// jtkcpu bus responder: decodes CPU cycles into internal RAM, external ROM
// or unmapped space, inserts wait states and returns data with dtack.
module jtkcpu_bussrv
    import jtkcpu_bussrv_pkg::*;
#(
    parameter int          RAM_AW    = 11,
    parameter logic [23:0] RAM_START = 24'h00_0000,
    parameter int          ROM_AW    = 16,
    parameter logic [23:0] ROM_START = 24'h01_0000,
    parameter int          RAM_WAIT  = 0,
    parameter int          TIMEOUT   = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    jtkcpu_bussrv_if.slave bus,
    output state_t         o_dbg_state
);
    state_t              r_state;
    region_t             r_region;
    logic [CNT_W-1:0]    r_cnt;
    logic [RAM_AW-1:0]   r_addr;
    logic                r_we;
    logic [7:0]          r_wdata;
    logic                r_got;
    logic                r_dtack;
    logic                r_rom_cs;
    logic [ROM_AW-1:0]   r_rom_addr;
    logic                r_buserr;
    logic [7:0]          r_cpu_din;

    logic                w_ram_hit;
    logic                w_rom_hit;
    logic                w_rom_take;
    logic                w_ram_we;
    logic [RAM_AW-1:0]   w_ram_addr;
    logic [7:0]          w_ram_q;

    assign w_ram_hit = bus.addr[23:RAM_AW] == RAM_START[23:RAM_AW];
    assign w_rom_hit = bus.addr[23:ROM_AW] == ROM_START[23:ROM_AW];

    // Present the live address while idle so the read data is already
    // registered by the time WAIT expires, even with RAM_WAIT=0.
    assign w_ram_addr = (r_state == ST_IDLE) ? bus.addr[RAM_AW-1:0] : r_addr;
    assign w_ram_we   = (r_state == ST_WAIT) && bus.as && (r_cnt == '0)
                        && (r_region == RG_RAM) && r_we;

    // rom_ok is taken on any clk, except a cen edge that aborts the cycle
    assign w_rom_take = (r_state == ST_ROM) && !r_got && bus.rom_ok
                        && !(cen && !bus.as);

    jtkcpu_bussrv_ram #(.AW(RAM_AW)) u_ram (
        .clk    (clk),
        .i_cen  (cen),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_din  (r_wdata),
        .o_dout (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_region   <= RG_RAM;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_got      <= 1'b0;
            r_dtack    <= 1'b0;
            r_rom_cs   <= 1'b0;
            r_rom_addr <= '0;
            r_buserr   <= 1'b0;
            r_cpu_din  <= '0;
        end else begin
            r_buserr <= 1'b0;
            if (w_rom_take) begin
                r_cpu_din <= bus.rom_data;
                r_rom_cs  <= 1'b0;
                r_got     <= 1'b1;
            end
            if (cen) begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.as) begin
                            r_addr  <= bus.addr[RAM_AW-1:0];
                            r_we    <= bus.we;
                            r_wdata <= bus.cpu_dout;
                            if (w_ram_hit) begin
                                r_region <= RG_RAM;
                                r_cnt    <= CNT_W'(RAM_WAIT);
                                r_state  <= ST_WAIT;
                            end else if (w_rom_hit && !bus.we) begin
                                r_rom_cs   <= 1'b1;
                                r_rom_addr <= bus.addr[ROM_AW-1:0];
                                r_state    <= ST_ROM;
                            end else if (w_rom_hit) begin
                                r_region <= RG_ROMWR;
                                r_cnt    <= '0;
                                r_state  <= ST_WAIT;
                            end else begin
                                r_region <= RG_UNMAP;
                                r_cnt    <= CNT_W'(TIMEOUT - 1);
                                r_state  <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (!bus.as) begin
                            r_state <= ST_IDLE;
                        end else if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_state <= ST_ACK;
                            r_dtack <= 1'b1;
                            case (r_region)
                                RG_RAM: begin
                                    if (!r_we) r_cpu_din <= w_ram_q;
                                end
                                RG_UNMAP: begin
                                    r_buserr <= 1'b1;
                                    if (!r_we) r_cpu_din <= BUSSRV_UNMAPPED;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_ROM: begin
                        if (!bus.as) begin
                            r_state  <= ST_IDLE;
                            r_rom_cs <= 1'b0;
                            r_got    <= 1'b0;
                        end else if (r_got || bus.rom_ok) begin
                            r_state  <= ST_ACK;
                            r_dtack  <= 1'b1;
                            r_rom_cs <= 1'b0;
                            r_got    <= 1'b0;
                        end
                    end
                    ST_ACK: begin
                        if (!bus.as) begin
                            r_dtack <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.cpu_din  = r_cpu_din;
    assign bus.dtack    = r_dtack;
    assign bus.rom_cs   = r_rom_cs;
    assign bus.rom_addr = r_rom_addr;
    assign bus.buserr   = r_buserr;
    assign o_dbg_state  = r_state;
endmodule

// File: doc/jtkcpu_bussrv.md
# jtkcpu_bussrv

Bus responder for the jtkcpu memory bus: answers the CPU's `as`/`we`/`addr` cycles and returns data and `dtack`. Decodes each cycle into an internal RAM region, an external ROM region served through a request/acknowledge port, or unmapped space. Inserts programmable wait states per region. Sits between the CPU core and the board's memory/SDRAM layer, and serves as the memory model in CPU simulation benches.

## Interface
Parameters:
- `RAM_AW`, 11: internal RAM address width, 2 kB.
- `RAM_START`, 24'h00_0000: RAM base; only bits [23:RAM_AW] are compared.
- `ROM_AW`, 16: ROM window address width.
- `ROM_START`, 24'h01_0000: ROM base; only bits [23:ROM_AW] are compared.
- `RAM_WAIT`, 0: extra cen cycles before a RAM access completes (0..15).
- `TIMEOUT`, 15: cen cycles before an unmapped access is acknowledged (1..255).

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, asynchronous, active-low.
- `cen` in 1: clock enable; the FSM and counters advance only on `cen`.
- `as` in 1: CPU address strobe, active-high. `addr`/`we`/`cpu_dout` are stable while it is high.
- `we` in 1: CPU write enable.
- `addr` in 24: CPU address.
- `cpu_dout` in 8: CPU write data.
- `cpu_din` out 8: read data to the CPU.
- `dtack` out 1: cycle complete, level signal.
- `rom_cs` out 1: ROM request.
- `rom_addr` out ROM_AW: ROM byte address.
- `rom_data` in 8: ROM read data.
- `rom_ok` in 1: ROM data valid. Sampled on every `clk`.
- `buserr` out 1: one-`clk` pulse when an unmapped access completes.

## Operation
- States: IDLE, WAIT, ROM, ACK.
- Decode priority is RAM, then ROM, then unmapped.
- IDLE, on a cen edge with `as`=1:
  - Latch `addr`, `we` and `cpu_dout`.
  - RAM hit: go to WAIT, cnt=RAM_WAIT.
  - ROM read: go to ROM, set `rom_cs`=1, `rom_addr`=addr[ROM_AW-1:0].
  - ROM write: go to WAIT, cnt=0. The write is discarded and `rom_cs` stays low.
  - Unmapped: go to WAIT, cnt=TIMEOUT-1.
- WAIT, on a cen edge:
  - If cnt≠0, decrement cnt.
  - If cnt=0, perform the access and go to ACK with `dtack`=1:
    - RAM write: write RAM.
    - RAM read: `cpu_din` gets RAM data.
    - Unmapped read: `cpu_din`=8'hFF and pulse `buserr`. An unmapped write also pulses `buserr`.
- ROM:
  - On the first `clk` with `rom_ok`=1: latch `rom_data` into `cpu_din`, drop `rom_cs`, set the `got` flag.
  - At the next cen edge with `got`=1: go to ACK with `dtack`=1 and clear `got`.
- ACK: `dtack` holds 1 until a cen edge sees `as`=0. Then `dtack`=0 and the FSM returns to IDLE.
- `as` staying high in ACK never starts a new cycle. The CPU must drop `as` between cycles.
- Abort: `as`=0 at a cen edge in WAIT or ROM returns to IDLE with `dtack`=0. No RAM write happens, `rom_cs` drops, `got` clears, and any late `rom_ok` is ignored.
- `cpu_din` holds its last value outside ACK.
- Reset (`rst`=0, any time, including mid-cycle):
  - FSM goes to IDLE.
  - `dtack`, `rom_cs`, `buserr`, `cpu_din`, `rom_addr` and the counters are all 0.
  - RAM contents are not cleared.

## Timing
- All latency is counted in cen edges; edge N is the one that samples `as`=1 in IDLE.
- RAM: `dtack` rises at edge N+1+RAM_WAIT, with `cpu_din` valid in the same cycle.
- Unmapped: `dtack` rises at edge N+TIMEOUT.
- ROM write: `dtack` rises at edge N+1.
- ROM read:
  - `rom_cs` is high from the `clk` after edge N.
  - If `rom_ok` arrives before edge N+1, `dtack` rises at N+1. Otherwise it rises at the first cen edge after `rom_ok`.
  - `rom_ok` arriving on a cen cycle counts for that edge.
- `dtack` fall: at the first cen edge with `as`=0 while in ACK.
- Back-to-back: the earliest next cycle is sampled at the edge after the one that returns to IDLE.
- `cen` held low freezes everything except `rom_ok` capture.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Include file `jtkcpu_bussrv.vh` holds:
  - state encodings (2-bit IDLE/WAIT/ROM/ACK);
  - the unmapped read value 8'hFF.
- Sub-module `jtkcpu_bussrv_ram`:
  - single-port synchronous RAM, parameter AW;
  - write on `we` & `cen`, registered read;
  - inferable as block RAM.
- The counter width is 8 bits, sized for TIMEOUT.

## Test plan
- RAM write 8'h5A to 24'h000123 with RAM_WAIT=0, then read the same address -> `dtack` at N+1 both times; the read returns 8'h5A.
- RAM_WAIT=3: read 24'h000010 -> `dtack` at N+4, and not before.
- ROM read 24'h01ABCD with `rom_ok` 7 clk late (`rom_data`=8'hC3) -> `rom_addr`=16'hABCD; `rom_cs` drops the clk after `rom_ok`; `cpu_din`=8'hC3 with `dtack`.
- Unmapped read 24'hFF0000 with TIMEOUT=15 -> `dtack` at N+15, `cpu_din`=8'hFF, `buserr` high for exactly one clk.
- Abort: drop `as` during the RAM_WAIT=3 wait of a write of 8'h11 -> no `dtack`; a later read of that address returns the old value.
- Assert `rst` low in ROM state, release it, then pulse `rom_ok` -> all outputs 0, FSM in IDLE, the stray `rom_ok` is ignored, and the next cycle completes normally.
